// File: rtl/riscv_core_pipe_ctrl.sv
// Hazard/sequencing controller for the RV64I 5-stage pipeline registers and PC.
// Optional perf counters are enabled by defining PIPE_CTRL_PERF_EN.
module riscv_core_pipe_ctrl #(
  parameter int W_REG_ADDR     = 5,
  parameter int INIT_FLUSH_CYC = 2,
  parameter int DWAIT_TIMEOUT  = 255,
  parameter int W_PERF         = 16
) (
  input  logic                  i_ctrl_clk,
  input  logic                  i_ctrl_rst,
  input  logic [W_REG_ADDR-1:0] i_id_rs1,
  input  logic [W_REG_ADDR-1:0] i_id_rs2,
  input  logic                  i_id_rs1_used,
  input  logic                  i_id_rs2_used,
  input  logic [W_REG_ADDR-1:0] i_ex_rd,
  input  logic                  i_ex_is_load,
  input  logic                  i_ex_redirect,
  input  logic                  i_trap,
  input  logic                  i_imem_ready,
  input  logic                  i_dmem_req,
  input  logic                  i_dmem_ready,
  output logic                  o_pc_en_n,
  output logic                  o_if_id_en_n,
  output logic                  o_if_id_clr,
  output logic                  o_id_ex_en_n,
  output logic                  o_id_ex_clr,
  output logic                  o_ex_mem_en_n,
  output logic                  o_ex_mem_clr,
  output logic                  o_mem_wb_en_n,
  output logic                  o_mem_wb_clr,
  output logic [1:0]            o_ctrl_state,
  output logic                  o_ctrl_err,
  output logic [W_PERF-1:0]     o_perf_stall_cnt,
  output logic [W_PERF-1:0]     o_perf_flush_cnt
);

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DWAIT = 2'd2;
  localparam logic [1:0] ST_TOUT  = 2'd3;

  localparam int W_INIT = (INIT_FLUSH_CYC > 1) ? $clog2(INIT_FLUSH_CYC) : 1;
  localparam int W_TO   = $clog2(DWAIT_TIMEOUT + 2);
  localparam logic [W_INIT-1:0] INIT_LAST = W_INIT'(INIT_FLUSH_CYC - 1);
  localparam logic [W_TO-1:0]   TO_LIMIT  = W_TO'(DWAIT_TIMEOUT);

  logic [1:0]        state_r, next_state_s;
  logic [W_INIT-1:0] init_cnt_r;
  logic [W_TO-1:0]   to_cnt_r;
  logic              load_use_s;
  logic              pc_en_n_s, if_id_en_n_s, if_id_clr_s, id_ex_en_n_s, id_ex_clr_s;
  logic              ex_mem_en_n_s, ex_mem_clr_s, mem_wb_en_n_s, mem_wb_clr_s, err_s;

  assign load_use_s = i_ex_is_load && (i_ex_rd != {W_REG_ADDR{1'b0}}) &&
                      ((i_id_rs1_used && (i_id_rs1 == i_ex_rd)) ||
                       (i_id_rs2_used && (i_id_rs2 == i_ex_rd)));

  // Next-state and stage-control decode; defaults are the full-flush pattern
  always_comb begin
    next_state_s  = state_r;
    pc_en_n_s     = 1'b1;
    if_id_en_n_s  = 1'b1;  if_id_clr_s  = 1'b1;
    id_ex_en_n_s  = 1'b1;  id_ex_clr_s  = 1'b1;
    ex_mem_en_n_s = 1'b1;  ex_mem_clr_s = 1'b1;
    mem_wb_en_n_s = 1'b1;  mem_wb_clr_s = 1'b1;
    err_s         = 1'b0;
    case (state_r)
      ST_INIT: begin
        if (init_cnt_r == INIT_LAST) begin
          next_state_s = ST_RUN;
        end else begin
          next_state_s = ST_INIT;
        end
      end
      ST_RUN, ST_DWAIT: begin
        next_state_s = ST_RUN;
        if (i_trap) begin
          pc_en_n_s = 1'b0;
        end else if (i_dmem_req && !i_dmem_ready) begin
          if_id_clr_s  = 1'b0;
          id_ex_clr_s  = 1'b0;
          ex_mem_clr_s = 1'b0;
          if ((DWAIT_TIMEOUT != 0) && (state_r == ST_DWAIT) && (to_cnt_r == TO_LIMIT)) begin
            next_state_s = ST_TOUT;
          end else begin
            next_state_s = ST_DWAIT;
          end
        end else if (i_ex_redirect) begin
          pc_en_n_s     = 1'b0;
          ex_mem_en_n_s = 1'b0;  ex_mem_clr_s = 1'b0;
          mem_wb_en_n_s = 1'b0;  mem_wb_clr_s = 1'b0;
        end else if (load_use_s) begin
          if_id_clr_s   = 1'b0;
          ex_mem_en_n_s = 1'b0;  ex_mem_clr_s = 1'b0;
          mem_wb_en_n_s = 1'b0;  mem_wb_clr_s = 1'b0;
        end else if (!i_imem_ready) begin
          id_ex_en_n_s  = 1'b0;  id_ex_clr_s  = 1'b0;
          ex_mem_en_n_s = 1'b0;  ex_mem_clr_s = 1'b0;
          mem_wb_en_n_s = 1'b0;  mem_wb_clr_s = 1'b0;
        end else begin
          pc_en_n_s     = 1'b0;
          if_id_en_n_s  = 1'b0;  if_id_clr_s  = 1'b0;
          id_ex_en_n_s  = 1'b0;  id_ex_clr_s  = 1'b0;
          ex_mem_en_n_s = 1'b0;  ex_mem_clr_s = 1'b0;
          mem_wb_en_n_s = 1'b0;  mem_wb_clr_s = 1'b0;
        end
      end
      ST_TOUT: begin
        next_state_s = ST_TOUT;
        if_id_clr_s  = 1'b0;
        id_ex_clr_s  = 1'b0;
        ex_mem_clr_s = 1'b0;
        mem_wb_clr_s = 1'b0;
        err_s        = 1'b1;
      end
      default: begin
        next_state_s = ST_INIT;
      end
    endcase
  end

  // State, init-flush counter and dmem-wait timeout counter
  always_ff @(posedge i_ctrl_clk or posedge i_ctrl_rst) begin
    if (i_ctrl_rst) begin
      state_r    <= ST_INIT;
      init_cnt_r <= {W_INIT{1'b0}};
      to_cnt_r   <= {W_TO{1'b0}};
    end else begin
      state_r <= next_state_s;
      if ((state_r == ST_INIT) && (init_cnt_r != INIT_LAST)) begin
        init_cnt_r <= init_cnt_r + W_INIT'(1);
      end else begin
        init_cnt_r <= init_cnt_r;
      end
      if (next_state_s == ST_DWAIT) begin
        to_cnt_r <= (state_r == ST_DWAIT) ? (to_cnt_r + W_TO'(1)) : W_TO'(1);
      end else begin
        to_cnt_r <= {W_TO{1'b0}};
      end
    end
  end

  assign o_pc_en_n     = pc_en_n_s;
  assign o_if_id_en_n  = if_id_en_n_s;
  assign o_if_id_clr   = if_id_clr_s;
  assign o_id_ex_en_n  = id_ex_en_n_s;
  assign o_id_ex_clr   = id_ex_clr_s;
  assign o_ex_mem_en_n = ex_mem_en_n_s;
  assign o_ex_mem_clr  = ex_mem_clr_s;
  assign o_mem_wb_en_n = mem_wb_en_n_s;
  assign o_mem_wb_clr  = mem_wb_clr_s;
  assign o_ctrl_state  = state_r;
  assign o_ctrl_err    = err_s;

`ifdef PIPE_CTRL_PERF_EN
  logic [W_PERF-1:0] stall_cnt_r, flush_cnt_r;
  logic              active_s, flush_evt_s;

  // Only trap and redirect load the PC while clearing IF/ID
  assign active_s    = (state_r == ST_RUN) || (state_r == ST_DWAIT);
  assign flush_evt_s = active_s && !pc_en_n_s && if_id_clr_s;

  // Saturating stall/flush event counters
  always_ff @(posedge i_ctrl_clk or posedge i_ctrl_rst) begin
    if (i_ctrl_rst) begin
      stall_cnt_r <= {W_PERF{1'b0}};
      flush_cnt_r <= {W_PERF{1'b0}};
    end else begin
      if (active_s && pc_en_n_s && (stall_cnt_r != {W_PERF{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + W_PERF'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_evt_s && (flush_cnt_r != {W_PERF{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + W_PERF'(1);
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign o_perf_stall_cnt = stall_cnt_r;
  assign o_perf_flush_cnt = flush_cnt_r;
`else
  assign o_perf_stall_cnt = {W_PERF{1'b0}};
  assign o_perf_flush_cnt = {W_PERF{1'b0}};
`endif

endmodule

// File: tb/tb_riscv_core_pipe_ctrl.sv
// Directed scoreboard bench for riscv_core_pipe_ctrl (DWAIT_TIMEOUT=4, W_PERF=2).
module tb_riscv_core_pipe_ctrl;

  localparam logic [8:0] V_FLUSH = 9'b1_11_11_11_11;
  localparam logic [8:0] V_ADV   = 9'b0_00_00_00_00;
  localparam logic [8:0] V_TRAP  = 9'b0_11_11_11_11;
  localparam logic [8:0] V_DWAIT = 9'b1_10_10_10_11;
  localparam logic [8:0] V_REDIR = 9'b0_11_11_00_00;
  localparam logic [8:0] V_LDUSE = 9'b1_10_11_00_00;
  localparam logic [8:0] V_IMEM  = 9'b1_11_00_00_00;
  localparam logic [8:0] V_TOUT  = 9'b1_10_10_10_10;

  typedef struct packed {
    logic [8:0] vec;
    logic [1:0] st;
    logic       err;
    logic [1:0] stall;
    logic [1:0] flush;
  } exp_t;

  logic       clk = 1'b0, rst = 1'b1;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       rs1_used, rs2_used, ex_is_load, ex_redirect, trap, imem_ready, dmem_req, dmem_ready;
  logic       pc_en_n, if_id_en_n, if_id_clr, id_ex_en_n, id_ex_clr;
  logic       ex_mem_en_n, ex_mem_clr, mem_wb_en_n, mem_wb_clr, err;
  logic [1:0] state, stall_cnt, flush_cnt;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  logic [1:0] m_stall = 2'd0, m_flush = 2'd0;

  riscv_core_pipe_ctrl #(
    .W_REG_ADDR(5), .INIT_FLUSH_CYC(2), .DWAIT_TIMEOUT(4), .W_PERF(2)
  ) dut (
    .i_ctrl_clk(clk), .i_ctrl_rst(rst),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_id_rs1_used(rs1_used), .i_id_rs2_used(rs2_used),
    .i_ex_rd(ex_rd), .i_ex_is_load(ex_is_load), .i_ex_redirect(ex_redirect),
    .i_trap(trap), .i_imem_ready(imem_ready),
    .i_dmem_req(dmem_req), .i_dmem_ready(dmem_ready),
    .o_pc_en_n(pc_en_n),
    .o_if_id_en_n(if_id_en_n), .o_if_id_clr(if_id_clr),
    .o_id_ex_en_n(id_ex_en_n), .o_id_ex_clr(id_ex_clr),
    .o_ex_mem_en_n(ex_mem_en_n), .o_ex_mem_clr(ex_mem_clr),
    .o_mem_wb_en_n(mem_wb_en_n), .o_mem_wb_clr(mem_wb_clr),
    .o_ctrl_state(state), .o_ctrl_err(err),
    .o_perf_stall_cnt(stall_cnt), .o_perf_flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    rs1_used = 1'b0; rs2_used = 1'b0; ex_is_load = 1'b0; ex_redirect = 1'b0;
    trap = 1'b0; imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b1;
  endtask

  // Push the expectation for the driven inputs, then pop and compare mid-cycle
  task automatic push_exp(input logic [8:0] vec, input logic [1:0] st);
    exp_t e;
    e.vec = vec; e.st = st; e.err = (st == 2'd3);
`ifdef PIPE_CTRL_PERF_EN
    e.stall = m_stall; e.flush = m_flush;
`else
    e.stall = 2'd0; e.flush = 2'd0;
`endif
    sb_q.push_back(e);
  endtask

  task automatic check_pop(input string tag);
    exp_t e;
    logic [8:0] got;
    checks++;
    assert (sb_q.size() > 0) else begin
      errors++; $error("FAIL %s queue: got empty expected entry", tag);
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      got = {pc_en_n, if_id_en_n, if_id_clr, id_ex_en_n, id_ex_clr,
             ex_mem_en_n, ex_mem_clr, mem_wb_en_n, mem_wb_clr};
      checks++;
      assert (got === e.vec) else begin
        errors++; $error("FAIL %s ctrl: got %b expected %b", tag, got, e.vec);
      end
      checks++;
      assert (state === e.st) else begin
        errors++; $error("FAIL %s state: got %0d expected %0d", tag, state, e.st);
      end
      checks++;
      assert (err === e.err) else begin
        errors++; $error("FAIL %s err: got %b expected %b", tag, err, e.err);
      end
      checks++;
      assert ({stall_cnt, flush_cnt} === {e.stall, e.flush}) else begin
        errors++; $error("FAIL %s perf: got %0d/%0d expected %0d/%0d",
                         tag, stall_cnt, flush_cnt, e.stall, e.flush);
      end
      if ((e.st == 2'd1) || (e.st == 2'd2)) begin
        if (e.vec[8] && (m_stall != 2'd3)) m_stall = m_stall + 2'd1;
        if (((e.vec == V_TRAP) || (e.vec == V_REDIR)) && (m_flush != 2'd3)) m_flush = m_flush + 2'd1;
      end
    end
  endtask

  task automatic step(input string tag, input logic [8:0] vec, input logic [1:0] st);
    push_exp(vec, st);
    #3;
    check_pop(tag);
    @(posedge clk); #1;
  endtask

  initial begin
    idle();
    @(posedge clk); #1;
    step("reset", V_FLUSH, 2'd0);
    rst = 1'b0;
    step("init1", V_FLUSH, 2'd0);
    trap = 1'b1;
    step("init2_ign", V_FLUSH, 2'd0);
    idle();
    step("run_adv", V_ADV, 2'd1);

    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; rs2_used = 1'b1;
    step("lduse", V_LDUSE, 2'd1);
    idle();
    step("lduse_after", V_ADV, 2'd1);
    ex_is_load = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; rs2_used = 1'b1;
    step("lduse_x0", V_ADV, 2'd1);
    ex_rd = 5'd5; id_rs1 = 5'd5; rs2_used = 1'b0;
    step("lduse_unused", V_ADV, 2'd1);
    id_rs2 = 5'd5; rs2_used = 1'b1; ex_redirect = 1'b1;
    step("redir_lduse", V_REDIR, 2'd1);
    idle();
    ex_redirect = 1'b1; imem_ready = 1'b0;
    step("redir_imem", V_REDIR, 2'd1);
    ex_redirect = 1'b0;
    step("imem_wait", V_IMEM, 2'd1);
    idle();
    dmem_req = 1'b1;
    step("dmem_same", V_ADV, 2'd1);

    dmem_ready = 1'b0;
    step("dw_enter", V_DWAIT, 2'd1);
    step("dw_2", V_DWAIT, 2'd2);
    step("dw_3", V_DWAIT, 2'd2);
    dmem_ready = 1'b1;
    step("dw_done", V_ADV, 2'd2);
    idle();
    step("dw_back", V_ADV, 2'd1);

    dmem_req = 1'b1; dmem_ready = 1'b0;
    step("dwt_enter", V_DWAIT, 2'd1);
    trap = 1'b1;
    step("dwt_trap", V_TRAP, 2'd2);
    trap = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b1;
    step("dwt_after", V_ADV, 2'd1);
    trap = 1'b1; ex_redirect = 1'b1;
    step("trap_run", V_TRAP, 2'd1);
    idle();

    dmem_req = 1'b1; dmem_ready = 1'b0;
    step("to_enter", V_DWAIT, 2'd1);
    for (int i = 1; i <= 4; i++) step("to_wait", V_DWAIT, 2'd2);
    step("tout", V_TOUT, 2'd3);
    trap = 1'b1; dmem_ready = 1'b1;
    step("tout_trap", V_TOUT, 2'd3);

    #2;
    rst = 1'b1;
    #1;
    m_stall = 2'd0; m_flush = 2'd0;
    push_exp(V_FLUSH, 2'd0);
    check_pop("async_rst");
    @(posedge clk); #1;
    idle();
    step("rst_hold", V_FLUSH, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
